// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry defaults, address widths,
// pixel and request types, FSM states and the linear-index helper.
package fb_pkg;

   localparam int H_CELLS_DEF = 80;
   localparam int V_CELLS_DEF = 60;
   localparam int FB_DEPTH    = H_CELLS_DEF * V_CELLS_DEF;

   localparam int COL_W  = 7;
   localparam int ROW_W  = 6;
   localparam int ADDR_W = 13;
   localparam int PIX_W  = 12;

   // RGB444, packed as {r,g,b}
   typedef logic [PIX_W-1:0] pixel_t;

   typedef struct packed {
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      pixel_t           data;
   } wr_req_t;

   typedef enum logic [1:0] {
      DRAW    = 2'd0,
      PENDING = 2'd1,
      CLEAR   = 2'd2
   } fb_state_t;

   // row*h_cells + col; the default 80-wide geometry uses row*64 + row*16
   // so no multiplier is built.
   function automatic logic [ADDR_W-1:0] lin_idx(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input int h_cells);
      if (h_cells == 80)
         return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
      return ADDR_W'(int'(row) * h_cells + int'(col));
   endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM, one write port and one registered
// read port on a single clock. Contents are never reset.
module fb_bank
   import fb_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  pixel_t            wdata,
   input  logic [ADDR_W-1:0] raddr,
   output pixel_t            rdata
);

   pixel_t mem [DEPTH];

   // write port plus registered read (read-before-write on collision)
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store. The display reads the front bank with one
// cycle of latency; the writer fills the back bank and requests a swap with
// frame_done, which is taken on the next vertical-sync falling edge.
// Optional build macro FB_CLEAR_EN: after each swap the new back bank is
// swept to 12'h000, one word per cycle, with writes held off.
module frame_buffer
   import fb_pkg::*;
#(
   parameter int H_CELLS = H_CELLS_DEF,
   parameter int V_CELLS = V_CELLS_DEF
) (
   input  logic             vga_clk,
   input  logic             clr,
   input  logic [COL_W-1:0] col_addr,
   input  logic [ROW_W-1:0] row_addr,
   input  logic             vs,
   output logic [PIX_W-1:0] dout,
   input  logic             wr_en,
   output logic             wr_ready,
   input  logic [COL_W-1:0] wr_col,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             frame_done,
   output logic             front_sel,
   output logic             swap_pulse
);

   localparam int               DEPTH    = H_CELLS * V_CELLS;
   localparam logic [COL_W-1:0] H_LIM    = COL_W'(H_CELLS);
   localparam logic [ROW_W-1:0] V_LIM    = ROW_W'(V_CELLS);
`ifdef FB_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
`endif

   fb_state_t state, state_nx;
   logic      vs_q, vs_fall, swap_req, clr_we;

   // read side
   logic                        rd_ok, rd_vld_q, rd_sel_q;
   logic [ADDR_W-1:0]           rd_idx;
   logic [1:0][PIX_W-1:0]       bank_rdata;

   // write side
   wr_req_t                     wreq;
   logic                        wr_ok, wr_fire;
   logic [ADDR_W-1:0]           wr_idx;
   logic [1:0]                  bank_we;
   logic [ADDR_W-1:0]           bank_waddr;
   pixel_t                      bank_wdata;

`ifdef FB_CLEAR_EN
   logic [ADDR_W-1:0]           clr_cnt;
`endif

   assign vs_fall = vs_q & ~vs;

   // Out-of-range reads park the RAM address at 0; the data is masked anyway.
   assign rd_ok  = (col_addr < H_LIM) && (row_addr < V_LIM);
   assign rd_idx = rd_ok ? lin_idx(row_addr, col_addr, H_CELLS) : '0;

   // Out-of-range writes are accepted (handshake completes) but never reach a bank.
   assign wreq    = '{col: wr_col, row: wr_row, data: wr_data};
   assign wr_ok   = (wreq.col < H_LIM) && (wreq.row < V_LIM);
   assign wr_idx  = lin_idx(wreq.row, wreq.col, H_CELLS);
   assign wr_fire = wr_en & wr_ready & wr_ok;

   genvar b;
   generate
      for (b = 0; b < 2; b++) begin : g_bank
         fb_bank #(.DEPTH(DEPTH)) u_bank (
            .clk   (vga_clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .raddr (rd_idx),
            .rdata (bank_rdata[b])
         );
      end
   endgenerate

   // Back-bank write steering: writer pixels, or the clear sweep when enabled.
   always_comb begin
      bank_we    = '0;
      bank_waddr = wr_idx;
      bank_wdata = wreq.data;
`ifdef FB_CLEAR_EN
      if (clr_we) begin
         bank_waddr = clr_cnt;
         bank_wdata = '0;
      end
`endif
      bank_we[~front_sel] = wr_fire | clr_we;
   end

   // State register.
   always_ff @(posedge vga_clk or posedge clr) begin
      if (clr) state <= DRAW;
      else     state <= state_nx;
   end

   // Next state and FSM outputs. vs edges are only acted on in PENDING, so a
   // fall coincident with frame_done waits for the next frame.
   always_comb begin
      state_nx = state;
      wr_ready = 1'b0;
      swap_req = 1'b0;
      clr_we   = 1'b0;
      case (state)
         DRAW: begin
            wr_ready = 1'b1;
            if (frame_done) state_nx = PENDING;
         end
         PENDING: begin
            if (vs_fall) begin
               swap_req = 1'b1;
`ifdef FB_CLEAR_EN
               state_nx = CLEAR;
`else
               state_nx = DRAW;
`endif
            end
         end
`ifdef FB_CLEAR_EN
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_cnt == LAST_IDX) state_nx = DRAW;
         end
`endif
         default: state_nx = DRAW;
      endcase
   end

   // vs history, bank select and the swap strobe (high while front_sel shows the new bank's first cycle).
   always_ff @(posedge vga_clk or posedge clr) begin
      if (clr) begin
         vs_q       <= 1'b1;
         front_sel  <= 1'b0;
         swap_pulse <= 1'b0;
      end else begin
         vs_q       <= vs;
         swap_pulse <= swap_req;
         if (swap_req) front_sel <= ~front_sel;
      end
   end

`ifdef FB_CLEAR_EN
   // Clear sweep address, wraps to 0 after the last word.
   always_ff @(posedge vga_clk or posedge clr) begin
      if (clr)
         clr_cnt <= '0;
      else if (clr_we)
         clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + 1'b1;
   end
`endif

   // Read qualifiers travel alongside the RAM read so bank choice and range
   // mask line up with the data they belong to.
   always_ff @(posedge vga_clk or posedge clr) begin
      if (clr) begin
         rd_vld_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_ok;
         rd_sel_q <= front_sel;
      end
   end

   assign dout = rd_vld_q ? bank_rdata[rd_sel_q] : '0;

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 Parameter H_CELLS, default 80, visible columns per row.
REQ-002 Parameter V_CELLS, default 60, visible rows per frame.
REQ-003 vga_clk  in  1  sole clock; all logic rising-edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 col_addr  in  7  read column from display stage.
REQ-006 row_addr  in  6  read row from display stage.
REQ-007 vs  in  1  vertical sync from display stage, active-low pulse.
REQ-008 dout  out  12  RGB444 pixel {r,g,b} to display stage din.
REQ-009 wr_en  in  1  writer presents a pixel.
REQ-010 wr_ready  out  1  write accepted when wr_en and wr_ready are both high at a rising edge.
REQ-011 wr_col  in  7, wr_row  in  6, wr_data  in  12  write address and pixel.
REQ-012 frame_done  in  1  one-cycle pulse: writer finished back buffer, requests swap.
REQ-013 front_sel  out  1  bank currently displayed.
REQ-014 swap_pulse  out  1  one-cycle pulse on the cycle front_sel toggles.

Function
REQ-015 Two banks of H_CELLS*V_CELLS 12-bit words; linear index = row*H_CELLS + col, 13 bits, computed by shift-add (row<<6 + row<<4 + col for default).
REQ-016 Read: dout registered, 1-cycle latency from col_addr/row_addr, always from bank front_sel.
REQ-017 Read with col_addr>=H_CELLS or row_addr>=V_CELLS -> dout=12'h000 one cycle later.
REQ-018 Write: accepted writes go only to bank ~front_sel; out-of-range addresses are accepted and dropped, no wrap.
REQ-019 FSM states DRAW, PENDING, CLEAR.
REQ-020 DRAW: wr_ready=1; frame_done -> PENDING next cycle; a write in the same cycle as frame_done is committed.
REQ-021 PENDING: wr_ready=0; on detected vs falling edge (vs_q=1, vs=0): front_sel toggles, swap_pulse=1, then -> CLEAR (if enabled) else DRAW.
REQ-022 vs edge detection uses one registered copy of vs; edges seen while in DRAW are ignored, so a vs fall coincident with frame_done does not swap; swap waits for next frame.
REQ-023 frame_done while in PENDING or CLEAR is ignored.
REQ-024 Swap never occurs mid-frame; display reads one bank for an entire frame.

Reset
REQ-025 On clr: state=DRAW, front_sel=0, swap_pulse=0, dout=0, wr_ready=1, vs_q=1, clear counter=0.
REQ-026 clr mid-PENDING or mid-CLEAR aborts the operation; RAM contents are not reset and are undefined after reset mid-CLEAR.

Configuration
REQ-027 Macro FB_CLEAR_EN defined: after each swap, state CLEAR sweeps new back bank addresses 0..H_CELLS*V_CELLS-1, one word/cycle, writing 12'h000; wr_ready=0 throughout; after last address -> DRAW (4800 cycles for default).
REQ-028 FB_CLEAR_EN undefined: CLEAR state absent; swap goes directly to DRAW; back bank retains previous-frame contents.

Structure
REQ-029 Shared package fb_pkg holds H_CELLS/V_CELLS defaults, FB_DEPTH, address widths, FSM state enum, pixel type (12-bit RGB444).
REQ-030 Sub-module fb_bank: single-clock simple dual-port RAM, one write port, one registered read port; instantiated twice.

Verification
REQ-031 Reset then read (0,0) on both banks after known writes -> dout matches front bank only, 1-cycle latency.
REQ-032 Write (5,3)=12'hF00, frame_done, vs fall -> swap_pulse one cycle, front_sel=1, read (5,3) gives 12'hF00 next cycle.
REQ-033 frame_done and vs fall same cycle -> no swap; swap on following vs fall only; wr_ready low in between.
REQ-034 Read (80,0) and (0,60) -> dout=0; write (100,10) -> wr_ready high, no bank change.
REQ-035 FB_CLEAR_EN: after swap, wr_ready low exactly 4800 cycles, then back bank reads all 12'h000; without macro, wr_ready high cycle after swap and old data persists.
REQ-036 clr asserted in PENDING -> immediately front_sel=0, wr_ready=1, dout=0, no swap_pulse.
